// File: rtl/instr_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder:
// opcode values, field bit positions, error codes, loader FSM states,
// and the record packing / range-check helpers.
package instr_pkg;

    // Opcodes (bits [31:29] of every instruction word)
    localparam logic [2:0] OP_RR      = 3'b000;
    localparam logic [2:0] OP_IMM     = 3'b001;
    localparam logic [2:0] OP_LOADIMM = 3'b010;
    localparam logic [2:0] OP_MEM     = 3'b011;
    localparam logic [2:0] OP_BRANCH  = 3'b100;

    // Field least-significant bit positions
    localparam int OPC_LSB     = 29;
    localparam int SUB_LSB     = 25;
    localparam int RD_LSB      = 20;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 10;
    localparam int LI_RD_LSB   = 24;
    localparam int MEM_RW_BIT  = 28;
    localparam int MEM_REG_LSB = 23;
    localparam int BR_TYPE_LSB = 27;

    // Error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_RESERVED = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Pack one decoded record into a 32-bit ISA word. Reserved opcodes
    // fall back to the RR layout.
    function automatic logic [31:0] encode_word(
        input logic [2:0]  op,
        input logic [3:0]  sub,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic [4:0]  mem_reg;
        w = 32'(op) << OPC_LSB;
        mem_reg = sub[0] ? rs1 : rd;
        case (op)
            OP_IMM: begin
                w = w | (32'(sub) << SUB_LSB) | (32'(rd) << RD_LSB)
                      | (32'(rs1) << RS1_LSB) | {17'b0, imm[14:0]};
            end
            OP_LOADIMM: begin
                w = w | (32'(rd) << LI_RD_LSB) | {8'b0, imm[23:0]};
            end
            OP_MEM: begin
                w = w | (32'(sub[0]) << MEM_RW_BIT) | (32'(mem_reg) << MEM_REG_LSB)
                      | {9'b0, imm[22:0]};
            end
            OP_BRANCH: begin
                w = w | (32'(sub[1:0]) << BR_TYPE_LSB) | {5'b0, imm[26:0]};
            end
            default: begin
                w = w | (32'(sub) << SUB_LSB) | (32'(rd) << RD_LSB)
                      | (32'(rs1) << RS1_LSB) | (32'(rs2) << RS2_LSB);
            end
        endcase
        return w;
    endfunction

    // Classify a record: reserved opcode, payload that does not fit its field, or fine.
    function automatic logic [1:0] check_record(
        input logic [2:0]  op,
        input logic [31:0] imm
    );
        logic [1:0] code;
        code = ERR_NONE;
        case (op)
            OP_RR:      code = ERR_NONE;
            OP_IMM:     if (imm[31:14] != {18{imm[31]}}) code = ERR_RANGE;
            OP_LOADIMM: if (imm[31:23] != {9{imm[31]}})  code = ERR_RANGE;
            OP_MEM:     if (imm[31:23] != 9'd0)          code = ERR_RANGE;
            OP_BRANCH:  if (imm[31:27] != 5'd0)          code = ERR_RANGE;
            default:    code = ERR_RESERVED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// sync_fifo: single-clock FIFO, no pop-through. full/empty come from a
// registered occupancy count, so a pop never frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage write; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction records into ISA words, buffers
// them, and writes them to consecutive instruction-memory addresses.
// Optional build macro ENCODER_RANGE_CHECK_EN: drop and flag records with a
// reserved opcode or an out-of-range payload instead of truncating them.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [3:0]        in_sub,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              done,
    output logic              wrap,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   err_index
);
    // Handshake: a record transfers on a rising edge where in_valid and
    // in_ready are both high; a word is written where imem_we and
    // imem_ready are both high. Neither side may depend on the other.

    enc_state_t        state;
    logic [ADDR_W-1:0] wptr;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              accept;
    logic              write;

    assign enc_word   = encode_word(in_opcode, in_sub, in_rd, in_rs1, in_rs2, in_imm);
    assign in_ready   = (state == ST_RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign imem_we    = !fifo_empty;
    assign write      = imem_we && imem_ready;
    assign imem_addr  = wptr;
    // Stale storage never leaks out while the buffer is empty
    assign imem_wdata = fifo_empty ? 32'd0 : fifo_dout;

`ifdef ENCODER_RANGE_CHECK_EN
    logic [1:0]      rec_err;
    logic [ADDR_W:0] rec_cnt;

    assign rec_err   = check_record(in_opcode, in_imm);
    assign fifo_push = accept && (rec_err == ERR_NONE);

    // Record counter and first-error capture, cleared when a session opens
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_cnt   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else if (state == ST_IDLE && start) begin
            rec_cnt   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else if (accept) begin
            rec_cnt <= rec_cnt + 1'b1;
            if (rec_err != ERR_NONE && !err) begin
                err       <= 1'b1;
                err_code  <= rec_err;
                err_index <= rec_cnt;
            end
        end
    end
`else
    logic unused_imm_hi;

    assign fifo_push     = accept;
    assign err           = 1'b0;
    assign err_code      = ERR_NONE;
    assign err_index     = '0;
    assign unused_imm_hi = ^in_imm[31:27];
`endif

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (write),
        .din   (enc_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Session FSM plus write pointer, word count and wrap tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            words_written <= '0;
            wrap          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_RUN;
                        wptr          <= start_addr;
                        words_written <= '0;
                        wrap          <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (finish) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (write) begin
                wptr          <= wptr + 1'b1;
                words_written <= words_written + 1'b1;
                if (&wptr) wrap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Expected words and addresses come
// from an arithmetic model of the ISA field rules, held in a queue and
// compared against every observed memory write.
module tb_instr_encoder;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_WAIT   = 300;
    localparam logic [31:0] BOUND [8] = '{32'h0000_3FFF, 32'hFFFF_C000, 32'h0000_4000,
                                          32'h007F_FFFF, 32'h0080_0000, 32'h07FF_FFFF,
                                          32'h0800_0000, 32'hFF80_0000};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              finish = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_opcode = '0;
    logic [3:0]        in_sub = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              done;
    logic              wrap;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   err_index;

    logic ready_drv = 1'b0;
    logic ready_rnd = 1'b0;
    logic rand_ready = 1'b0;
    assign imem_ready = rand_ready ? ready_rnd : ready_drv;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [ADDR_W-1:0] m_ptr;
    int                m_words;
    logic              m_wrap;
    logic              m_err;
    logic [1:0]        m_code;
    int                m_index;
    int                m_rec;

    instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_sub(in_sub), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .words_written(words_written),
        .done(done), .wrap(wrap), .err(err), .err_code(err_code), .err_index(err_index)
    );

    // Clock and random memory back-pressure source
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1 ready_rnd = 1'($urandom_range(0, 1));
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_word(input logic [2:0] op, input logic [3:0] sub,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [31:0] imm);
        longint w;
        longint u;
        u = longint'(imm);
        w = longint'(op) * (64'd1 << 29);
        case (op)
            3'd1: w = w + sub * (64'd1 << 25) + rd * (64'd1 << 20) + rs1 * (64'd1 << 15)
                        + (u % (64'd1 << 15));
            3'd2: w = w + rd * (64'd1 << 24) + (u % (64'd1 << 24));
            3'd3: w = w + (sub % 2) * (64'd1 << 28) + ((sub % 2 == 1) ? rs1 : rd) * (64'd1 << 23)
                        + (u % (64'd1 << 23));
            3'd4: w = w + (sub % 4) * (64'd1 << 27) + (u % (64'd1 << 27));
            default: w = w + sub * (64'd1 << 25) + rd * (64'd1 << 20) + rs1 * (64'd1 << 15)
                           + rs2 * (64'd1 << 10);
        endcase
        return w[31:0];
    endfunction

    // 0 = fine, 1 = reserved opcode, 2 = payload does not fit
    function automatic int model_err(input logic [2:0] op, input logic [31:0] imm);
        longint sv;
        longint u;
        sv = longint'($signed(imm));
        u  = longint'(imm);
        case (op)
            3'd0: return 0;
            3'd1: return (sv < -16384 || sv > 16383) ? 2 : 0;
            3'd2: return (sv < -8388608 || sv > 8388607) ? 2 : 0;
            3'd3: return (u >= (64'd1 << 23)) ? 2 : 0;
            3'd4: return (u >= (64'd1 << 27)) ? 2 : 0;
            default: return 1;
        endcase
    endfunction

    task automatic model_accept(input logic [2:0] op, input logic [3:0] sub, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int e;
        e = 0;
`ifdef ENCODER_RANGE_CHECK_EN
        e = model_err(op, imm);
`endif
        if (e != 0) begin
            if (!m_err) begin
                m_err   = 1'b1;
                m_code  = 2'(e);
                m_index = m_rec;
            end
        end else begin
            exp_q.push_back(model_word(op, sub, rd, rs1, rs2, imm));
            exp_addr_q.push_back(m_ptr);
            if (m_ptr == '1) m_wrap = 1'b1;
            m_ptr = m_ptr + 1'b1;
            m_words++;
        end
        m_rec++;
    endtask

    // ---------------- scoreboard on the memory side ----------------
    always @(negedge clk) begin : monitor
        logic [31:0]       ed;
        logic [ADDR_W-1:0] ea;
        if (done) done_count++;
        if (!reset && imem_we && imem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got %h at %h, required no write", imem_wdata, imem_addr);
            end else begin
                ed = exp_q.pop_front();
                ea = exp_addr_q.pop_front();
                if (imem_wdata !== ed || imem_addr !== ea) begin
                    errors++;
                    $display("FAIL write_word: got %h at %h, required %h at %h", imem_wdata, imem_addr, ed, ea);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] addr);
        start = 1'b1;
        start_addr = addr;
        tick();
        start = 1'b0;
        m_ptr = addr; m_words = 0; m_wrap = 1'b0;
        m_err = 1'b0; m_code = 2'b00; m_index = 0; m_rec = 0;
    endtask

    task automatic finish_session();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic send_record(input logic [2:0] op, input logic [3:0] sub, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                               input bit with_finish);
        bit ok;
        ok = 1'b0;
        in_opcode = op; in_sub = sub; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int c = 0; c < MAX_WAIT; c++) begin
            @(negedge clk);
            if (in_ready) begin
                if (with_finish) finish = 1'b1;
                @(posedge clk);
                model_accept(op, sub, rd, rs1, rs2, imm);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        finish = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never high for opcode %0d, required acceptance", op);
        end
    endtask

    task automatic rand_record(output logic [2:0] op, output logic [3:0] sub, output logic [4:0] rd,
                               output logic [4:0] rs1, output logic [4:0] rs2, output logic [31:0] imm);
        op  = 3'($urandom_range(0, 7));
        sub = 4'($urandom);
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 255));
            2: imm = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: imm = BOUND[$urandom_range(0, 7)];
        endcase
    endtask

    // Wait for done, then compare session results and the one-cycle pulse
    task automatic end_session(input string name);
        int d0;
        bit seen;
        d0 = done_count;
        seen = 1'b0;
        for (int c = 0; c < MAX_WAIT; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, required a done pulse", name, MAX_WAIT);
        end else begin
            checks += 6;
            if (words_written !== (ADDR_W+1)'(m_words)) begin
                errors++;
                $display("FAIL %s_words_written: got %0d, required %0d", name, words_written, m_words);
            end
            if (wrap !== m_wrap) begin
                errors++;
                $display("FAIL %s_wrap: got %b, required %b", name, wrap, m_wrap);
            end
            if (err !== m_err || err_code !== m_code) begin
                errors++;
                $display("FAIL %s_err: got %b/%b, required %b/%b", name, err, err_code, m_err, m_code);
            end
            if (err_index !== (ADDR_W+1)'(m_index)) begin
                errors++;
                $display("FAIL %s_err_index: got %0d, required %0d", name, err_index, m_index);
            end
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s_pending: %0d words never written, required 0", name, exp_q.size());
            end
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_ready_in_done: got %b, required 0", name, in_ready);
            end
            @(negedge clk);
            checks += 2;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_width: done still %b, required 0", name, done);
            end
            if (done_count != d0 + 1) begin
                errors++;
                $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_count - d0);
            end
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b, required 0", imem_we); end
        if (imem_addr !== '0 || imem_wdata !== '0) begin
            errors++; $display("FAIL reset_imem_bus: got %h/%h, required 0/0", imem_addr, imem_wdata);
        end
        if (words_written !== '0) begin errors++; $display("FAIL reset_words: got %0d, required 0", words_written); end
        if (done !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL reset_done_wrap: got %b/%b, required 0/0", done, wrap);
        end
        if (err !== 1'b0 || err_code !== 2'b00 || err_index !== '0) begin
            errors++; $display("FAIL reset_err: got %b/%b/%0d, required 0/0/0", err, err_code, err_index);
        end
        // finish while idle is ignored
        tick();
        finish_session();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL idle_finish: done/in_ready %b/%b, required 0/0", done, in_ready);
            end
        end
        tick();
    endtask

    task automatic test_basic();
        ready_drv = 1'b1;
        start_session(10'h010);
        send_record(3'd0, 4'h3, 5'd2, 5'd1, 5'd3, 32'd0, 1'b0);
        checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'h0620_8C00 || imem_addr !== 10'h010) begin
            errors++;
            $display("FAIL basic_rr_latency: we=%b word=%h addr=%h, required 1/06208c00/010",
                     imem_we, imem_wdata, imem_addr);
        end
        finish_session();
        end_session("basic");
        checks++;
        if (words_written !== 11'd1) begin
            errors++; $display("FAIL basic_count: got %0d, required 1", words_written);
        end
    endtask

    task automatic test_formats();
        ready_drv = 1'b1;
        start_session(10'h020);
        send_record(3'd1, 4'h0, 5'd5, 5'd5, 5'd0, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (imem_wdata !== 32'h2052_FFFF) begin
            errors++; $display("FAIL fmt_imm: got %h, required 2052ffff", imem_wdata);
        end
        send_record(3'd2, 4'h0, 5'd7, 5'd0, 5'd0, 32'h0080_0000, 1'b0);
        checks++;
`ifdef ENCODER_RANGE_CHECK_EN
        if (imem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b10 || err_index !== 11'd1) begin
            errors++;
            $display("FAIL fmt_loadimm_range: we=%b err=%b code=%b idx=%0d, required 0/1/10/1",
                     imem_we, err, err_code, err_index);
        end
`else
        if (imem_wdata !== 32'h4780_0000 || err !== 1'b0) begin
            errors++; $display("FAIL fmt_loadimm: got %h err=%b, required 47800000 err=0", imem_wdata, err);
        end
`endif
        send_record(3'd3, 4'h1, 5'd9, 5'd4, 5'd0, 32'h0000_0012, 1'b0);
        checks++;
        if (imem_wdata !== 32'h7200_0012) begin
            errors++; $display("FAIL fmt_mem_store: got %h, required 72000012", imem_wdata);
        end
        send_record(3'd4, 4'h2, 5'd0, 5'd0, 5'd0, 32'h0000_0040, 1'b0);
        checks++;
        if (imem_wdata !== 32'h9000_0040) begin
            errors++; $display("FAIL fmt_branch: got %h, required 90000040", imem_wdata);
        end
        send_record(3'd3, 4'h0, 5'd9, 5'd4, 5'd0, 32'h007F_FFFF, 1'b0);
        send_record(3'd2, 4'h0, 5'd3, 5'd0, 5'd0, 32'hFF80_0000, 1'b0);
        finish_session();
        end_session("formats");
    endtask

    task automatic test_backpressure();
        logic [2:0]  op  [6];
        logic [3:0]  sub [6];
        logic [4:0]  rd  [6];
        logic [4:0]  rs1 [6];
        logic [4:0]  rs2 [6];
        int acc;
        bit r;
        for (int i = 0; i < 6; i++) begin
            op[i] = 3'd0; sub[i] = 4'($urandom); rd[i] = 5'($urandom);
            rs1[i] = 5'($urandom); rs2[i] = 5'($urandom);
        end
        ready_drv = 1'b0;
        start_session(10'h100);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_opcode = op[acc]; in_sub = sub[acc]; in_rd = rd[acc];
            in_rs1 = rs1[acc]; in_rs2 = rs2[acc]; in_imm = 32'd0;
            in_valid = 1'b1;
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                model_accept(op[acc], sub[acc], rd[acc], rs1[acc], rs2[acc], 32'd0);
                acc++;
            end
            #1;
        end
        in_valid = 1'b0;
        checks += 2;
        if (acc != FIFO_DEPTH || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepts: got %0d accepts in_ready=%b, required 4/0", acc, in_ready);
        end
        if (imem_we !== 1'b1 || words_written !== '0) begin
            errors++; $display("FAIL bp_stall: we=%b words=%0d, required 1/0", imem_we, words_written);
        end
        ready_drv = 1'b1;
        for (int i = acc; i < 6; i++) send_record(op[i], sub[i], rd[i], rs1[i], rs2[i], 32'd0, 1'b0);
        finish_session();
        end_session("backpressure");
    endtask

    task automatic test_wrap();
        ready_drv = 1'b1;
        start_session(10'h3FF);
        send_record(3'd1, 4'h5, 5'd1, 5'd2, 5'd0, 32'h0000_0123, 1'b0);
        send_record(3'd1, 4'h6, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFF0, 1'b0);
        finish_session();
        end_session("wrap");
        checks++;
        if (wrap !== 1'b1 || imem_addr !== 10'h001) begin
            errors++; $display("FAIL wrap_sticky: wrap=%b ptr=%h, required 1/001", wrap, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [3:0]  sub;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        rand_ready = 1'b1;
        start_session(10'($urandom));
        for (int i = 0; i < 40; i++) begin
            rand_record(op, sub, rd, rs1, rs2, imm);
            send_record(op, sub, rd, rs1, rs2, imm, 1'b0);
        end
        rand_record(op, sub, rd, rs1, rs2, imm);
        send_record(op, sub, rd, rs1, rs2, imm, 1'b1);
        end_session("back_to_back");
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d0;
        ready_drv = 1'b0;
        start_session(10'h200);
        for (int i = 0; i < 3; i++) send_record(3'd0, 4'(i), 5'(i), 5'd1, 5'd2, 32'd0, 1'b0);
        checks++;
        if (imem_we !== 1'b1) begin errors++; $display("FAIL mid_pending: we=%b, required 1", imem_we); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        ready_drv = 1'b1;
        d0 = done_count;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({imem_we, in_ready, done, wrap, err, err_code, imem_addr, imem_wdata,
                 words_written, err_index} !== '0) begin
                errors++;
                $display("FAIL mid_reset_outputs: we=%b rdy=%b done=%b addr=%h data=%h words=%0d, required all 0",
                         imem_we, in_ready, done, imem_addr, imem_wdata, words_written);
            end
        end
        checks++;
        if (done_count != d0) begin
            errors++; $display("FAIL mid_reset_done: got %0d pulses, required 0", done_count - d0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_formats();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
